// File: rtl/pico_cpu_if.sv
// Board-side I/O bundle of the pico_cpu core: switch handshake and operand in, LED result out.
interface pico_cpu_if;
  logic       handshake;
  logic [7:0] index;
  logic [7:0] result;

  modport master (output handshake, output index, input result);
  modport slave  (input handshake, input index, output result);
endinterface

// File: rtl/pico_cpu.sv
// Single-cycle 8-bit picoMIPS-style core: waits for the handshake, computes
// sat(((index*COEF)>>8) + OFFSET) from a fixed ROM program and shows it on the LEDs.
module pico_cpu #(
  parameter logic [7:0] COEF   = 8'd192,
  parameter logic [7:0] OFFSET = 8'd20
) (
  input  logic      clk,
  input  logic      reset,
  pico_cpu_if.slave io
);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_IN   = 4'd1;
  localparam logic [3:0] OP_OUT  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_ADDI = 4'd4;
  localparam logic [3:0] OP_MULI = 4'd5;
  localparam logic [3:0] OP_BH1  = 4'd6;
  localparam logic [3:0] OP_BH0  = 4'd7;
  localparam logic [3:0] OP_J    = 4'd8;

  // Word layout: op[17:14] rd[13:11] rs[10:8] imm[7:0]
  function automatic logic [17:0] rom_word(input logic [4:0] addr);
    case (addr)
      5'd0:    rom_word = {OP_BH1,  3'd0, 3'd0, 8'd0};
      5'd1:    rom_word = {OP_IN,   3'd1, 3'd0, 8'd0};
      5'd2:    rom_word = {OP_MULI, 3'd2, 3'd1, COEF};
      5'd3:    rom_word = {OP_ADDI, 3'd2, 3'd2, OFFSET};
      5'd4:    rom_word = {OP_OUT,  3'd0, 3'd2, 8'd0};
      5'd5:    rom_word = {OP_BH0,  3'd0, 3'd0, 8'd5};
      5'd6:    rom_word = {OP_J,    3'd0, 3'd0, 8'd0};
      default: rom_word = {OP_NOP,  3'd0, 3'd0, 8'd0};
    endcase
  endfunction

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  logic [4:0]  pc;
  logic [4:0]  pc_next;
  logic [7:0]  regs [8];
  logic [7:0]  result_q;
  logic [17:0] instr;
  logic [3:0]  op;
  logic [2:0]  rd;
  logic [2:0]  rs;
  logic [7:0]  imm;
  logic [7:0]  rd_val;
  logic [7:0]  rs_val;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        out_en;

  assign instr  = rom_word(pc);
  assign op     = instr[17:14];
  assign rd     = instr[13:11];
  assign rs     = instr[10:8];
  assign imm    = instr[7:0];
  assign rd_val = (rd == 3'd0) ? 8'd0 : regs[rd];
  assign rs_val = (rs == 3'd0) ? 8'd0 : regs[rs];

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    pc_next = pc + 5'd1;
    wr_en   = 1'b0;
    wr_data = 8'd0;
    out_en  = 1'b0;
    case (op)
      OP_IN:   begin wr_en = 1'b1; wr_data = io.index; end
      OP_OUT:  out_en = 1'b1;
      OP_ADD:  begin wr_en = 1'b1; wr_data = sat_add(rd_val, rs_val); end
      OP_ADDI: begin wr_en = 1'b1; wr_data = sat_add(rs_val, imm); end
      OP_MULI: begin
        wr_en   = 1'b1;
        wr_data = 8'((16'(rs_val) * 16'(imm)) >> 8);
      end
      OP_BH1:  if (!io.handshake) pc_next = imm[4:0];
      OP_BH0:  if (io.handshake)  pc_next = imm[4:0];
      OP_J:    pc_next = imm[4:0];
      default: ;
    endcase
  end

  // NOTE: the register file is only eight flops deep, so it is reset along with the
  // rest of the state; larger memories would normally be left unreset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= 5'd0;
      result_q <= 8'd0;
      for (int i = 0; i < 8; i++) regs[i] <= 8'd0;
    end else begin
      pc <= pc_next;
      if (wr_en && rd != 3'd0) regs[rd] <= wr_data;
      if (out_en) result_q <= rs_val;
    end
  end

  assign io.result = result_q;

endmodule

// File: tb/tb_pico_cpu.sv
// Directed bench for pico_cpu: two instances (OFFSET 20 and 100) driven with the same inputs.
module tb_pico_cpu;

  logic clk = 1'b0;
  logic reset;

  pico_cpu_if io_a ();
  pico_cpu_if io_b ();

  pico_cpu #(.COEF(8'd192), .OFFSET(8'd20))  dut_a (.clk(clk), .reset(reset), .io(io_a.slave));
  pico_cpu #(.COEF(8'd192), .OFFSET(8'd100)) dut_b (.clk(clk), .reset(reset), .io(io_b.slave));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] index;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    bit         drop_early;
  } vec_t;

  vec_t       vecs [6];
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] prev_a = 8'd0;
  logic [7:0] prev_b = 8'd0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic hs, input logic [7:0] idx);
    io_a.handshake = hs;
    io_b.handshake = hs;
    io_a.index     = idx;
    io_b.index     = idx;
  endtask

  task automatic set_hs(input logic hs);
    io_a.handshake = hs;
    io_b.handshake = hs;
  endtask

  task automatic set_idx(input logic [7:0] idx);
    io_a.index = idx;
    io_b.index = idx;
  endtask

  // Starts from PC 0 with handshake low; leaves handshake high unless dropped early.
  task automatic run(input logic [7:0] idx, input logic [7:0] ea, input logic [7:0] eb,
                     input bit drop_early, input string name);
    @(negedge clk);
    drive(1'b1, idx);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0 && drop_early) set_hs(1'b0);
      if (k == 1) set_idx(~idx);
      check({name, " hold_a"}, io_a.result, prev_a);
      check({name, " hold_b"}, io_b.result, prev_b);
    end
    @(negedge clk);
    check({name, " out_a"}, io_a.result, ea);
    check({name, " out_b"}, io_b.result, eb);
    prev_a = ea;
    prev_b = eb;
  endtask

  task automatic release_hs(input string name);
    set_hs(1'b0);
    repeat (3) @(negedge clk);
    check({name, " after_release_a"}, io_a.result, prev_a);
    check({name, " after_release_b"}, io_b.result, prev_b);
  endtask

  initial begin
    vecs[0] = '{index: 8'd100, exp_a: 8'd95,  exp_b: 8'd175, drop_early: 1'b0};
    vecs[1] = '{index: 8'd255, exp_a: 8'd211, exp_b: 8'd255, drop_early: 1'b0};
    vecs[2] = '{index: 8'd0,   exp_a: 8'd20,  exp_b: 8'd100, drop_early: 1'b1};
    vecs[3] = '{index: 8'd128, exp_a: 8'd116, exp_b: 8'd196, drop_early: 1'b0};
    vecs[4] = '{index: 8'd1,   exp_a: 8'd20,  exp_b: 8'd100, drop_early: 1'b0};
    vecs[5] = '{index: 8'd200, exp_a: 8'd170, exp_b: 8'd250, drop_early: 1'b1};

    reset = 1'b1;
    drive(1'b0, 8'd0);
    #1 reset = 1'b0;
    #2;
    check("reset_a", io_a.result, 8'd0);
    check("reset_b", io_b.result, 8'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_a", io_a.result, 8'd0);
    end

    for (int i = 0; i < 6; i++) begin
      run(vecs[i].index, vecs[i].exp_a, vecs[i].exp_b, vecs[i].drop_early, $sformatf("vec%0d", i));
      release_hs($sformatf("vec%0d", i));
    end

    // A high pulse that is gone before the next edge must not start a run.
    @(negedge clk);
    drive(1'b1, 8'd50);
    #2 set_hs(1'b0);
    repeat (6) @(negedge clk);
    check("short_pulse_a", io_a.result, prev_a);

    // Handshake held high after a run: no re-run with a new index until it drops.
    run(8'd100, 8'd95, 8'd175, 1'b0, "held");
    set_idx(8'd200);
    repeat (10) @(negedge clk);
    check("held_high_a", io_a.result, 8'd95);
    check("held_high_b", io_b.result, 8'd175);
    release_hs("held");
    run(8'd200, 8'd170, 8'd250, 1'b0, "rerun");
    release_hs("rerun");

    // Reset mid-run, two edges after the sampling edge.
    @(negedge clk);
    drive(1'b1, 8'd255);
    repeat (3) @(negedge clk);
    check("pre_reset_a", io_a.result, 8'd170);
    #1 reset = 1'b0;
    #1;
    check("midrun_reset_a", io_a.result, 8'd0);
    check("midrun_reset_b", io_b.result, 8'd0);
    set_hs(1'b0);
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    check("post_reset_idle_a", io_a.result, 8'd0);
    prev_a = 8'd0;
    prev_b = 8'd0;
    run(8'd255, 8'd211, 8'd255, 1'b0, "post_reset");
    release_hs("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
